// File: rtl/trigger_reset_pkg.sv
// Shared constants and types for the trigger/reset sequencer.
// cfg bit positions, channel state encoding and sts field offsets.
package trigger_reset_pkg;

   localparam int CFG_TRIG_MODE  = 0;
   localparam int CFG_WD_EN      = 1;
   localparam int CFG_SATA_PROP  = 2;
   localparam int CFG_INST_EN    = 3;
   localparam int CFG_EXT_SEL    = 4;
   localparam int CFG_INT_EN     = 5;
   localparam int CFG_KEEP_ALIVE = 6;
   localparam int CFG_CLR_FAULT  = 7;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_RAMP_DOWN = 2'd2,
      ST_HOLD      = 2'd3
   } ch_state_e;

   localparam int STS_ARESETN_SYNC = 0;
   localparam int STS_FAULT        = 1;
   localparam int STS_WD_FAIL      = 2;
   localparam int STS_RAM_WR       = 3;
   localparam int STS_TRIG_EFF     = 4;
   localparam int STS_EXT_S        = 5;
   localparam int STS_WD_S         = 6;
   localparam int STS_INST_S       = 7;
   localparam int STS_RAMP_TO      = 8;
   localparam int STS_CH_STATE     = 16;

endpackage

// File: rtl/channel_ramp_fsm.sv
// One DAC channel: reset / run / ramp-down / hold sequencing.
// Owns its ramp timeout counter and sticky timeout flag.
module channel_ramp_fsm
   import trigger_reset_pkg::*;
#(
   parameter int RAMP_TIMEOUT_CYCLES = 1250000
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      en,
   input  logic      trig,
   input  logic      trig_mode,
   input  logic      fault,
   input  logic      clr,
   input  logic      ramp_down_req,
   input  logic      ramp_enable,
   input  logic      ramp_done,
   output ch_state_e state,
   output logic      ch_aresetn,
   output logic      start_ramp_down,
   output logic      ramp_timeout
);

   localparam int RW = $clog2(RAMP_TIMEOUT_CYCLES + 1);
   localparam logic [RW-1:0] R_LAST = RW'(RAMP_TIMEOUT_CYCLES - 1);

   ch_state_e     state_d;
   logic [RW-1:0] rcnt;
   logic          hold_exit;
   logic          timeout;

   assign hold_exit = (~trig | ~trig_mode) & ~fault & ~ramp_down_req;
   assign timeout   = (state == ST_RAMP_DOWN) && (rcnt == R_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rcnt         <= '0;
         ramp_timeout <= 1'b0;
      end else begin
         state <= state_d;
         if (state == ST_RAMP_DOWN)
            rcnt <= rcnt + RW'(1);
         else if (state == ST_HOLD && hold_exit)
            rcnt <= '0;
         if (clr)
            ramp_timeout <= 1'b0;
         else if (timeout && !ramp_done)
            ramp_timeout <= 1'b1;
      end
   end

   always_comb begin
      state_d         = state;
      ch_aresetn      = 1'b0;
      start_ramp_down = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (en && (!trig_mode || trig) && !fault)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            ch_aresetn = 1'b1;
            // fault outranks a falling trigger
            if (fault || ramp_down_req)
               state_d = ramp_enable ? ST_RAMP_DOWN : ST_HOLD;
            else if (trig_mode && !trig)
               state_d = ramp_enable ? ST_RAMP_DOWN : ST_IDLE;
         end
         ST_RAMP_DOWN: begin
            ch_aresetn      = 1'b1;
            start_ramp_down = 1'b1;
            if (ramp_done || timeout)
               state_d = ST_HOLD;
         end
         ST_HOLD: begin
            start_ramp_down = 1'b1;
            if (hold_exit)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/trigger_reset_sequencer.sv
// Shared trigger, watchdog and fault handling for NUM_CHANNELS DAC
// reset/ramp-down sequences plus heartbeat and status word.
module trigger_reset_sequencer
   import trigger_reset_pkg::*;
#(
   parameter int NUM_CHANNELS            = 2,
   parameter int CLK_HZ                  = 125000000,
   parameter int ALIVE_LOW_CYCLES        = 12500000,
   parameter int ALIVE_HIGH_CYCLES       = 1250000,
   parameter int WATCHDOG_TIMEOUT_CYCLES = 12500000,
   parameter int RAMP_TIMEOUT_CYCLES     = 1250000
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic [7:0]              cfg,
   input  logic                    is_master,
   input  logic                    counter_trigger,
   input  logic                    ext_trigger,
   input  logic                    sata_trigger,
   input  logic                    watchdog,
   input  logic                    instant_reset,
   input  logic [NUM_CHANNELS-1:0] ramp_enable,
   input  logic [NUM_CHANNELS-1:0] ramp_down_req,
   input  logic [NUM_CHANNELS-1:0] ramp_done,
   output logic [NUM_CHANNELS-1:0] ch_aresetn,
   output logic [NUM_CHANNELS-1:0] ch_start_ramp_down,
   output logic                    pdm_aresetn,
   output logic                    ram_writer_aresetn,
   output logic                    keep_alive_aresetn,
   output logic                    sata_out,
   output logic                    master_trigger,
   output logic                    alive_signal,
   output logic                    reset_ack,
   output logic [31:0]             sts
);

   localparam int WW = $clog2(WATCHDOG_TIMEOUT_CYCLES + 1);
   localparam int AP = ALIVE_LOW_CYCLES + ALIVE_HIGH_CYCLES;
   localparam int AW = $clog2(AP + 1);
   localparam logic [WW-1:0] WD_LAST    = WW'(WATCHDOG_TIMEOUT_CYCLES - 1);
   localparam logic [AW-1:0] ALIVE_LAST = AW'(AP - 1);
   localparam logic [AW-1:0] ALIVE_LOW  = AW'(ALIVE_LOW_CYCLES);
   localparam bit PARAMS_OK =
      (NUM_CHANNELS >= 1) && (NUM_CHANNELS <= 8) && (CLK_HZ >= 2) &&
      (ALIVE_LOW_CYCLES >= 2) && (ALIVE_HIGH_CYCLES >= 2) &&
      (WATCHDOG_TIMEOUT_CYCLES >= 2) && (RAMP_TIMEOUT_CYCLES >= 2);

   logic [3:0]    meta;
   logic [3:0]    sync;
   logic          ext_trigger_s, sata_trigger_s, watchdog_s, instant_reset_s;
   logic          aresetn_sync;
   logic          trig_eff;
   logic          fault;
   logic          wd_prev, wd_fail;
   logic [WW-1:0] wd_cnt;
   logic [AW-1:0] alive_cnt;
   ch_state_e     ch_state [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] ramp_timeout;

   assign {instant_reset_s, watchdog_s, sata_trigger_s, ext_trigger_s} = sync;

   assign fault        = wd_fail | (cfg[CFG_INST_EN] & instant_reset_s);
   assign sata_out     = trig_eff & cfg[CFG_SATA_PROP];
   assign pdm_aresetn  = |ch_aresetn;
   assign alive_signal = alive_cnt >= ALIVE_LOW;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         meta               <= '0;
         sync               <= '0;
         aresetn_sync       <= 1'b0;
         trig_eff           <= 1'b0;
         reset_ack          <= 1'b0;
         ram_writer_aresetn <= 1'b0;
         keep_alive_aresetn <= 1'b0;
         master_trigger     <= 1'b0;
         alive_cnt          <= '0;
      end else begin
         meta <= {instant_reset, watchdog, sata_trigger, ext_trigger};
         sync <= meta;
         // a misparametrised instance never leaves idle
         aresetn_sync <= PARAMS_OK;
         trig_eff <= cfg[CFG_EXT_SEL] ? ext_trigger_s :
                     (cfg[CFG_INT_EN] & counter_trigger) |
                     (~is_master & sata_trigger_s);
         reset_ack          <= fault;
         ram_writer_aresetn <= cfg[CFG_TRIG_MODE] ? (trig_eff & ~fault) : 1'b1;
         keep_alive_aresetn <= cfg[CFG_KEEP_ALIVE];
         master_trigger     <= cfg[CFG_INT_EN] & counter_trigger;
         alive_cnt <= (alive_cnt == ALIVE_LAST) ? '0 : alive_cnt + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wd_prev <= 1'b0;
         wd_cnt  <= '0;
         wd_fail <= 1'b0;
      end else begin
         wd_prev <= watchdog_s;
         // clearing the fault also restarts the timeout window
         if (!cfg[CFG_WD_EN] || cfg[CFG_CLR_FAULT]) begin
            wd_cnt  <= '0;
            wd_fail <= 1'b0;
         end else begin
            if (watchdog_s ^ wd_prev)
               wd_cnt <= '0;
            else if (wd_cnt != WD_LAST)
               wd_cnt <= wd_cnt + WW'(1);
            if (wd_cnt == WD_LAST)
               wd_fail <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      channel_ramp_fsm #(
         .RAMP_TIMEOUT_CYCLES(RAMP_TIMEOUT_CYCLES)
      ) u_fsm (
         .clk             (clk),
         .rst_n           (aresetn),
         .en              (aresetn_sync),
         .trig            (trig_eff),
         .trig_mode       (cfg[CFG_TRIG_MODE]),
         .fault           (reset_ack),
         .clr             (cfg[CFG_CLR_FAULT]),
         .ramp_down_req   (ramp_down_req[i]),
         .ramp_enable     (ramp_enable[i]),
         .ramp_done       (ramp_done[i]),
         .state           (ch_state[i]),
         .ch_aresetn      (ch_aresetn[i]),
         .start_ramp_down (ch_start_ramp_down[i]),
         .ramp_timeout    (ramp_timeout[i])
      );
   end

   always_comb begin
      sts                   = '0;
      sts[STS_ARESETN_SYNC] = aresetn_sync;
      sts[STS_FAULT]        = fault;
      sts[STS_WD_FAIL]      = wd_fail;
      sts[STS_RAM_WR]       = ram_writer_aresetn;
      sts[STS_TRIG_EFF]     = trig_eff;
      sts[STS_EXT_S]        = ext_trigger_s;
      sts[STS_WD_S]         = watchdog_s;
      sts[STS_INST_S]       = instant_reset_s;
      sts[STS_RAMP_TO +: NUM_CHANNELS] = ramp_timeout;
      for (int i = 0; i < NUM_CHANNELS; i++)
         sts[STS_CH_STATE + 2*i +: 2] = ch_state[i];
   end

endmodule

// File: tb/tb_trigger_reset_sequencer.sv
// Bench for trigger_reset_sequencer: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_trigger_reset_sequencer;

   localparam int NCH = 2;
   localparam int AL  = 5;
   localparam int AH  = 3;
   localparam int WDT = 32;
   localparam int RT  = 16;
   localparam int IDLE = 0, RUN = 1, RD = 2, HOLD = 3;

   logic           clk = 1'b0;
   logic           aresetn;
   logic [7:0]     cfg;
   logic           is_master, counter_trigger, ext_trigger;
   logic           sata_trigger, watchdog, instant_reset;
   logic [NCH-1:0] ramp_enable, ramp_down_req, ramp_done;
   logic [NCH-1:0] ch_aresetn, ch_start_ramp_down;
   logic           pdm_aresetn, ram_writer_aresetn, keep_alive_aresetn;
   logic           sata_out, master_trigger, alive_signal, reset_ack;
   logic [31:0]    sts;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   trigger_reset_sequencer #(
      .NUM_CHANNELS(NCH),
      .CLK_HZ(125000000),
      .ALIVE_LOW_CYCLES(AL),
      .ALIVE_HIGH_CYCLES(AH),
      .WATCHDOG_TIMEOUT_CYCLES(WDT),
      .RAMP_TIMEOUT_CYCLES(RT)
   ) dut (
      .clk(clk), .aresetn(aresetn), .cfg(cfg), .is_master(is_master),
      .counter_trigger(counter_trigger), .ext_trigger(ext_trigger),
      .sata_trigger(sata_trigger), .watchdog(watchdog),
      .instant_reset(instant_reset), .ramp_enable(ramp_enable),
      .ramp_down_req(ramp_down_req), .ramp_done(ramp_done),
      .ch_aresetn(ch_aresetn), .ch_start_ramp_down(ch_start_ramp_down),
      .pdm_aresetn(pdm_aresetn), .ram_writer_aresetn(ram_writer_aresetn),
      .keep_alive_aresetn(keep_alive_aresetn), .sata_out(sata_out),
      .master_trigger(master_trigger), .alive_signal(alive_signal),
      .reset_ack(reset_ack), .sts(sts)
   );

   // behavioural model state
   bit [1:0] m_ext, m_sata, m_wd, m_inst;
   bit       m_sync, m_wd_prev, m_wd_fail, m_trig, m_ack;
   bit       m_ram, m_keep, m_master;
   int       m_wd_idle, m_edges;
   int       m_st [NCH];
   int       m_rd [NCH];
   bit       m_rto [NCH];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ext = 0; m_sata = 0; m_wd = 0; m_inst = 0;
      m_sync = 0; m_wd_prev = 0; m_wd_fail = 0; m_trig = 0; m_ack = 0;
      m_ram = 0; m_keep = 0; m_master = 0; m_wd_idle = 0; m_edges = 0;
      for (int i = 0; i < NCH; i++) begin
         m_st[i] = IDLE; m_rd[i] = 0; m_rto[i] = 0;
      end
   endtask

   task automatic model_step();
      bit fault_o, wd_edge, hx, n_trig;
      int nst;
      if (!aresetn) begin
         model_reset();
         return;
      end
      fault_o = m_wd_fail | (cfg[3] & m_inst[1]);
      wd_edge = m_wd[1] != m_wd_prev;
      for (int i = 0; i < NCH; i++) begin
         nst = m_st[i];
         hx = (!m_trig || !cfg[0]) && !m_ack && !ramp_down_req[i];
         if (cfg[7]) m_rto[i] = 0;
         case (m_st[i])
            IDLE: if (m_sync && (!cfg[0] || m_trig) && !m_ack) nst = RUN;
            RUN: begin
               if (m_ack || ramp_down_req[i])
                  nst = ramp_enable[i] ? RD : HOLD;
               else if (cfg[0] && !m_trig)
                  nst = ramp_enable[i] ? RD : IDLE;
            end
            RD: begin
               if (m_rd[i] == RT - 1 && !ramp_done[i] && !cfg[7])
                  m_rto[i] = 1;
               if (ramp_done[i] || m_rd[i] == RT - 1) nst = HOLD;
               m_rd[i]++;
            end
            default: if (hx) nst = IDLE;
         endcase
         if (nst == RD && m_st[i] != RD) m_rd[i] = 0;
         m_st[i] = nst;
      end
      n_trig = cfg[4] ? m_ext[1] :
               ((cfg[5] & counter_trigger) | (!is_master & m_sata[1]));
      m_ram = cfg[0] ? (m_trig & !fault_o) : 1'b1;
      m_ack = fault_o;
      m_trig = n_trig;
      if (!cfg[1] || cfg[7]) begin
         m_wd_idle = 0; m_wd_fail = 0;
      end else begin
         if (m_wd_idle == WDT - 1) m_wd_fail = 1;
         if (wd_edge) m_wd_idle = 0;
         else if (m_wd_idle < WDT - 1) m_wd_idle++;
      end
      m_wd_prev = m_wd[1];
      m_ext  = {m_ext[0], ext_trigger};
      m_sata = {m_sata[0], sata_trigger};
      m_wd   = {m_wd[0], watchdog};
      m_inst = {m_inst[0], instant_reset};
      m_keep = cfg[6];
      m_master = cfg[5] & counter_trigger;
      m_sync = 1;
      m_edges++;
   endtask

   task automatic compare_all();
      logic [NCH-1:0] e_ch, e_srd;
      logic [31:0]    e_sts;
      e_sts = '0;
      for (int i = 0; i < NCH; i++) begin
         e_ch[i]  = (m_st[i] == RUN) || (m_st[i] == RD);
         e_srd[i] = (m_st[i] == RD) || (m_st[i] == HOLD);
         e_sts[8 + i] = m_rto[i];
         e_sts[16 + 2*i +: 2] = 2'(m_st[i]);
      end
      e_sts[0] = m_sync;
      e_sts[1] = m_wd_fail | (cfg[3] & m_inst[1]);
      e_sts[2] = m_wd_fail;
      e_sts[3] = m_ram;
      e_sts[4] = m_trig;
      e_sts[5] = m_ext[1];
      e_sts[6] = m_wd[1];
      e_sts[7] = m_inst[1];
      chk("m_ch_aresetn", ch_aresetn, e_ch);
      chk("m_srd", ch_start_ramp_down, e_srd);
      chk("m_pdm", pdm_aresetn, |e_ch);
      chk("m_ram_wr", ram_writer_aresetn, m_ram);
      chk("m_keep", keep_alive_aresetn, m_keep);
      chk("m_sata_out", sata_out, m_trig & cfg[2]);
      chk("m_master", master_trigger, m_master);
      chk("m_alive", alive_signal, (m_edges % (AL + AH)) >= AL);
      chk("m_reset_ack", reset_ack, m_ack);
      chk("m_sts", sts, e_sts);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      cfg = 8'h00; is_master = 1'b1; counter_trigger = 1'b0;
      ext_trigger = 1'b0; sata_trigger = 1'b0; watchdog = 1'b0;
      instant_reset = 1'b0; ramp_enable = '0; ramp_down_req = '0;
      ramp_done = '0; aresetn = 1'b0;
      ticks(2);
      aresetn = 1'b1;
   endtask

   initial begin
      logic [15:0] alive_pat;
      int wd_rate;
      alive_pat = 16'h7070;
      model_reset();
      do_reset();
      chk("rst_sts", sts, 32'h0);
      chk("rst_ch", ch_aresetn, 2'b00);
      chk("rst_ram", ram_writer_aresetn, 1'b0);

      // continuous mode
      tick();
      chk("t1_cyc1_ch", ch_aresetn, 2'b00);
      tick();
      chk("t1_cyc2_ch", ch_aresetn, 2'b11);
      chk("t1_ram", ram_writer_aresetn, 1'b1);
      chk("t1_state", sts[31:16], 16'h0005);

      // external trigger latency
      cfg = 8'h11;
      ticks(4);
      ext_trigger = 1'b1;
      ticks(3);
      chk("t2_trig_lat3", sts[4], 1'b1);
      chk("t2_ch_lat3", ch_aresetn, 2'b00);
      tick();
      chk("t2_ch_lat4", ch_aresetn, 2'b11);
      chk("t2_ram_lat4", ram_writer_aresetn, 1'b1);
      ext_trigger = 1'b0;
      ticks(3);
      chk("t2_fall_lat3", ch_aresetn, 2'b11);
      tick();
      chk("t2_fall_idle", sts[31:16], 16'h0000);

      // ramp handshake and ramp timeout
      cfg = 8'h19; ramp_enable = 2'b11; ext_trigger = 1'b1;
      ticks(5);
      instant_reset = 1'b1;
      tick();
      instant_reset = 1'b0;
      ticks(2);
      chk("t3_ack_lat3", reset_ack, 1'b1);
      chk("t3_srd_lat3", ch_start_ramp_down, 2'b00);
      tick();
      chk("t3_srd_lat4", ch_start_ramp_down, 2'b11);
      ticks(9);
      ramp_done = 2'b01;
      tick();
      ramp_done = 2'b00;
      chk("t3_ch0_hold", sts[17:16], 2'd3);
      chk("t3_ch1_rd", sts[19:18], 2'd2);
      ticks(5);
      chk("t3_ch1_pre_to", sts[19:18], 2'd2);
      tick();
      chk("t3_ch1_hold", sts[19:18], 2'd3);
      chk("t3_rto1", sts[9], 1'b1);
      chk("t3_rto0", sts[8], 1'b0);
      ext_trigger = 1'b0;
      ticks(4);
      chk("t3_hold_exit", sts[31:16], 16'h0000);
      cfg = 8'h99;
      tick();
      cfg = 8'h19;
      chk("t3_rto_clr", sts[9], 1'b0);

      // randomized run against the model
      wd_rate = 8;
      for (int n = 0; n < 3000; n++) begin
         if (n % 40 == 0) begin
            cfg = 8'($urandom);
            cfg[7] = ($urandom_range(0, 7) == 0);
            ramp_enable = NCH'($urandom);
            is_master = 1'($urandom_range(0, 1));
            wd_rate = $urandom_range(4, 60);
         end else begin
            cfg[7] = 1'b0;
         end
         aresetn = ($urandom_range(0, 299) != 0);
         counter_trigger = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) ext_trigger = ~ext_trigger;
         if ($urandom_range(0, 15) == 0) sata_trigger = ~sata_trigger;
         if ($urandom_range(1, wd_rate) == 1) watchdog = ~watchdog;
         instant_reset = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < NCH; i++) begin
            ramp_done[i] = ($urandom_range(0, 19) == 0);
            ramp_down_req[i] = ($urandom_range(0, 49) == 0);
         end
         tick();
      end

      // watchdog
      do_reset();
      cfg = 8'h13; ext_trigger = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ticks(20);
         watchdog = ~watchdog;
      end
      chk("t4_no_fault", reset_ack, 1'b0);
      chk("t4_no_wdfail", sts[2], 1'b0);
      chk("t4_run", sts[31:16], 16'h0005);
      ticks(40);
      chk("t4_wdfail", sts[2], 1'b1);
      chk("t4_ack", reset_ack, 1'b1);
      chk("t4_hold", sts[31:16], 16'h000F);
      cfg = 8'h93;
      tick();
      cfg = 8'h13; ext_trigger = 1'b0;
      chk("t4_wd_clr", sts[2], 1'b0);
      tick();
      chk("t4_ack_clr", reset_ack, 1'b0);
      ticks(4);
      chk("t4_hold_exit", sts[31:16], 16'h0000);

      // slave sata trigger
      do_reset();
      is_master = 1'b0; cfg = 8'h05; sata_trigger = 1'b1;
      ticks(2);
      chk("t5_trig_lat2", sts[4], 1'b0);
      tick();
      chk("t5_trig_lat3", sts[4], 1'b1);
      chk("t5_sata_out", sata_out, 1'b1);
      is_master = 1'b1;
      tick();
      chk("t5_master_ign", sts[4], 1'b0);
      chk("t5_sata_out0", sata_out, 1'b0);

      // alive heartbeat
      do_reset();
      for (int k = 0; k < 16; k++) begin
         tick();
         chk("t6_alive", alive_signal, alive_pat[k]);
      end

      // reset in the middle of a ramp
      cfg = 8'h19; ramp_enable = 2'b11; ext_trigger = 1'b1;
      ticks(5);
      instant_reset = 1'b1;
      tick();
      instant_reset = 1'b0;
      ticks(4);
      chk("t6_srd_pre", ch_start_ramp_down, 2'b11);
      aresetn = 1'b0;
      #1;
      chk("t6_rst_ch", ch_aresetn, 2'b00);
      chk("t6_rst_srd", ch_start_ramp_down, 2'b00);
      chk("t6_rst_pdm", pdm_aresetn, 1'b0);
      chk("t6_rst_ram", ram_writer_aresetn, 1'b0);
      chk("t6_rst_keep", keep_alive_aresetn, 1'b0);
      chk("t6_rst_sata", sata_out, 1'b0);
      chk("t6_rst_master", master_trigger, 1'b0);
      chk("t6_rst_alive", alive_signal, 1'b0);
      chk("t6_rst_ack", reset_ack, 1'b0);
      chk("t6_rst_sts", sts, 32'h0);
      tick();
      aresetn = 1'b1;
      ticks(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
